// File: rtl/le_buffer.sv
// VGA scan-out reader for a 320x240 frame buffer, shown at 640x480 with 2x2 pixel replication.
// Read addresses run READ_LATENCY pixels ahead of the display position, so returned words land on the right pixel.
module le_buffer #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int PIXEL_BITS   = 8,
  parameter int READ_LATENCY = 1   // legal range 1..4
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [10:0]           x_coord,
  output logic [10:0]           y_coord,
  output logic                  read_enable,
  input  logic [PIXEL_BITS-1:0] pixel_data,
  output logic [PIXEL_BITS-1:0] pixel_out,
  output logic                  hsync,
  output logic                  vsync,
  output logic                  blank_n,
  output logic                  frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST    = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS     = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS     = 11'(V_VISIBLE);
  localparam logic [10:0] HS_ON     = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_OFF    = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_ON     = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_OFF    = 11'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [10:0] H_PRELOAD = 11'(H_TOTAL - READ_LATENCY);

  logic [10:0] h, v;    // position being displayed
  logic [10:0] ha, va;  // position being fetched, READ_LATENCY pixels ahead
  logic        visible, ahead_visible;

  // Raster step: returns {v_next, h_next}
  function automatic logic [21:0] advance(input logic [10:0] hc, input logic [10:0] vc);
    logic [10:0] hn, vn;
    hn = hc + 11'd1;
    vn = vc;
    if (hc == H_LAST) begin
      hn = '0;
      vn = (vc == V_LAST) ? '0 : vc + 11'd1;
    end
    return {vn, hn};
  endfunction

  assign visible       = (h < H_VIS) && (v < V_VIS);
  assign ahead_visible = (ha < H_VIS) && (va < V_VIS);

  // Gated by reset directly so no read is issued while the counters are being loaded
  assign read_enable = reset && ahead_visible;
  assign x_coord     = read_enable ? {1'b0, ha[10:1]} : '0;
  assign y_coord     = read_enable ? {1'b0, va[10:1]} : '0;

  always_ff @(posedge clock) begin
    if (!reset) begin
      // Display trails the fetch counter, which starts at the frame origin
      h           <= H_PRELOAD;
      v           <= V_LAST;
      ha          <= '0;
      va          <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      blank_n     <= 1'b0;
      pixel_out   <= '0;
      frame_start <= 1'b0;
    end else begin
      {v, h}      <= advance(h, v);
      {va, ha}    <= advance(ha, va);
      blank_n     <= visible;
      pixel_out   <= visible ? pixel_data : '0;
      hsync       <= !((h >= HS_ON) && (h < HS_OFF));
      vsync       <= !((v >= VS_ON) && (v < VS_OFF));
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_le_buffer.sv
// Directed bench for le_buffer: one full-size instance (latency 1) and two reduced-geometry
// instances (latency 3 and 4), each fed by a buffer model returning (x + 7*y) mod 256.
module tb_le_buffer;

  logic        clock = 1'b0;
  logic        rst_n [3];
  logic        re_o  [3];
  logic [10:0] x_o   [3];
  logic [10:0] y_o   [3];
  logic [7:0]  pd    [3];
  logic [7:0]  po_o  [3];
  logic        hs_o  [3];
  logic        vs_o  [3];
  logic        bn_o  [3];
  logic        fs_o  [3];
  logic [7:0]  pipe  [3][4];

  int tests, fails;

  // trace history and timing measurements
  logic [7:0]  po_hist [4096];
  logic        re_hist [4096];
  logic        bn_hist [4096];
  logic [10:0] x_hist  [4096];
  logic [10:0] y_hist  [4096];
  int last_hs_fall, last_bn_fall, last_bn_rise, last_vs_fall, last_fs;
  int hs_period, hs_low, hs_after_bn, bn_run, hs_cnt, hs_per_vs, vs_low, vs_after_bn;
  int fs_spacing, first_fs;
  logic prev_hs, prev_vs, prev_bn, prev_fs;

  always #5 clock = ~clock;

  le_buffer u1 (
    .clock(clock), .reset(rst_n[0]), .x_coord(x_o[0]), .y_coord(y_o[0]),
    .read_enable(re_o[0]), .pixel_data(pd[0]), .pixel_out(po_o[0]),
    .hsync(hs_o[0]), .vsync(vs_o[0]), .blank_n(bn_o[0]), .frame_start(fs_o[0])
  );

  le_buffer #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIXEL_BITS(8), .READ_LATENCY(3)
  ) u3 (
    .clock(clock), .reset(rst_n[1]), .x_coord(x_o[1]), .y_coord(y_o[1]),
    .read_enable(re_o[1]), .pixel_data(pd[1]), .pixel_out(po_o[1]),
    .hsync(hs_o[1]), .vsync(vs_o[1]), .blank_n(bn_o[1]), .frame_start(fs_o[1])
  );

  le_buffer #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .PIXEL_BITS(8), .READ_LATENCY(4)
  ) u4 (
    .clock(clock), .reset(rst_n[2]), .x_coord(x_o[2]), .y_coord(y_o[2]),
    .read_enable(re_o[2]), .pixel_data(pd[2]), .pixel_out(po_o[2]),
    .hsync(hs_o[2]), .vsync(vs_o[2]), .blank_n(bn_o[2]), .frame_start(fs_o[2])
  );

  // Buffer model: fixed-latency read; non-read cycles return a marker that must never reach the pins
  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      pipe[i][0] <= re_o[i] ? 8'(int'(x_o[i]) + 7 * int'(y_o[i])) : 8'hA5;
      for (int k = 1; k < 4; k++) pipe[i][k] <= pipe[i][k-1];
    end
  end
  assign pd[0] = pipe[0][0];
  assign pd[1] = pipe[1][2];
  assign pd[2] = pipe[2][3];

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input int id, input string tag);
    chk({tag, " hsync"},       32'(hs_o[id]), 32'd1);
    chk({tag, " vsync"},       32'(vs_o[id]), 32'd1);
    chk({tag, " blank_n"},     32'(bn_o[id]), 32'd0);
    chk({tag, " pixel_out"},   32'(po_o[id]), 32'd0);
    chk({tag, " read_enable"}, 32'(re_o[id]), 32'd0);
    chk({tag, " frame_start"}, 32'(fs_o[id]), 32'd0);
    chk({tag, " x/y"},         32'({x_o[id], y_o[id]}), 32'd0);
  endtask

  task automatic meas_reset();
    last_hs_fall = -1; last_bn_fall = -1; last_bn_rise = -1; last_vs_fall = -1; last_fs = -1;
    hs_period = -1; hs_low = -1; hs_after_bn = -1; bn_run = -1; hs_cnt = 0; hs_per_vs = -1;
    vs_low = -1; vs_after_bn = -1; fs_spacing = -1; first_fs = -1;
    prev_hs = 1'b1; prev_vs = 1'b1; prev_bn = 1'b0; prev_fs = 1'b0;
  endtask

  // Expected pins for sample c after release: fetch position is c, display trails by latency, registered pins by one more
  task automatic expect_at(input int id, input int c, output logic e_re, output int e_x, output int e_y,
                           output logic e_bn, output int e_po, output logic e_hs, output logic e_vs,
                           output logic e_fs);
    int hv, ht, vv, vt, hs0, hs1, vs0, vs1, rl, ft, la, ld, h, v, ha, va;
    if (id == 0) begin
      hv = 640; ht = 800; vv = 480; vt = 525; hs0 = 656; hs1 = 752; vs0 = 490; vs1 = 492; rl = 1;
    end else begin
      hv = 16; ht = 24; vv = 8; vt = 12; hs0 = 18; hs1 = 21; vs0 = 9; vs1 = 11; rl = (id == 1) ? 3 : 4;
    end
    ft = ht * vt;
    la = c % ft; ha = la % ht; va = la / ht;
    e_re = (ha < hv) && (va < vv);
    e_x  = e_re ? ha / 2 : 0;
    e_y  = e_re ? va / 2 : 0;
    if (c == 0) begin
      e_bn = 1'b0; e_po = 0; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    end else begin
      ld = (c - 1 - rl + ft) % ft; h = ld % ht; v = ld / ht;
      e_bn = (h < hv) && (v < vv);
      e_po = e_bn ? ((h / 2) + 7 * (v / 2)) % 256 : 0;
      e_hs = !((h >= hs0) && (h < hs1));
      e_vs = !((v >= vs0) && (v < vs1));
      e_fs = (ld == 0);
    end
  endtask

  task automatic run_trace(input int id, input int c0, input int n, input string tag);
    int bad;
    string first;
    logic e_re, e_bn, e_hs, e_vs, e_fs;
    int e_x, e_y, e_po;
    bad = 0;
    first = "";
    for (int c = c0; c < c0 + n; c++) begin
      expect_at(id, c, e_re, e_x, e_y, e_bn, e_po, e_hs, e_vs, e_fs);
      if (re_o[id] !== e_re || x_o[id] !== 11'(e_x) || y_o[id] !== 11'(e_y) || bn_o[id] !== e_bn ||
          po_o[id] !== 8'(e_po) || hs_o[id] !== e_hs || vs_o[id] !== e_vs || fs_o[id] !== e_fs) begin
        bad++;
        if (bad == 1)
          first = $sformatf("c=%0d re=%b/%b x=%0d/%0d y=%0d/%0d bn=%b/%b po=%0d/%0d hs=%b/%b vs=%b/%b fs=%b/%b",
                            c, re_o[id], e_re, x_o[id], e_x, y_o[id], e_y, bn_o[id], e_bn,
                            po_o[id], e_po, hs_o[id], e_hs, vs_o[id], e_vs, fs_o[id], e_fs);
      end
      if (c < 4096) begin
        po_hist[c] = po_o[id]; re_hist[c] = re_o[id]; bn_hist[c] = bn_o[id];
        x_hist[c] = x_o[id]; y_hist[c] = y_o[id];
      end
      if (prev_bn && !bn_o[id]) begin
        if (last_bn_rise >= 0) bn_run = c - last_bn_rise;
        last_bn_fall = c;
      end
      if (!prev_bn && bn_o[id]) last_bn_rise = c;
      if (prev_hs && !hs_o[id]) begin
        if (last_hs_fall >= 0) hs_period = c - last_hs_fall;
        if (last_bn_fall >= 0) hs_after_bn = c - last_bn_fall;
        last_hs_fall = c;
        hs_cnt++;
      end
      if (!prev_hs && hs_o[id] && last_hs_fall >= 0) hs_low = c - last_hs_fall;
      if (prev_vs && !vs_o[id]) begin
        if (last_vs_fall >= 0) hs_per_vs = hs_cnt;
        hs_cnt = 0;
        if (last_bn_fall >= 0) vs_after_bn = c - last_bn_fall;
        last_vs_fall = c;
      end
      if (!prev_vs && vs_o[id] && last_vs_fall >= 0) vs_low = c - last_vs_fall;
      if (!prev_fs && fs_o[id]) begin
        if (last_fs >= 0) fs_spacing = c - last_fs;
        else first_fs = c;
        last_fs = c;
      end
      prev_bn = bn_o[id]; prev_hs = hs_o[id]; prev_vs = vs_o[id]; prev_fs = fs_o[id];
      step();
    end
    tests++;
    assert (bad === 0) else begin
      fails++;
      $error("FAIL %s: %0d bad samples, want 0; first (got/want) %s", tag, bad, first);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n[0] = 1'b0; rst_n[1] = 1'b0; rst_n[2] = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    chk_reset(0, "u1 reset");
    chk_reset(1, "u3 reset");
    chk_reset(2, "u4 reset");

    // Full-size timing, latency 1: first three lines
    rst_n[0] = 1'b1;
    #1;
    chk("u1 first read_enable", 32'(re_o[0]), 32'd1);
    chk("u1 first x", 32'(x_o[0]), 32'd0);
    chk("u1 first y", 32'(y_o[0]), 32'd0);
    meas_reset();
    run_trace(0, 0, 2403, "u1 lines 0-2 trace");
    chk("u1 x at c1", 32'(x_hist[1]), 32'd0);
    chk("u1 x at c2", 32'(x_hist[2]), 32'd1);
    chk("u1 first frame_start", 32'(first_fs), 32'd2);
    chk("u1 px0", 32'(po_hist[2]), 32'd0);
    chk("u1 px1", 32'(po_hist[3]), 32'd0);
    chk("u1 px2", 32'(po_hist[4]), 32'd1);
    chk("u1 px3", 32'(po_hist[5]), 32'd1);
    chk("u1 px638", 32'(po_hist[640]), 32'd63);
    chk("u1 line1 px638", 32'(po_hist[1440]), 32'd63);
    chk("u1 line2 px0", 32'(po_hist[1602]), 32'd7);
    chk("u1 line2 px2", 32'(po_hist[1604]), 32'd8);
    chk("u1 blank_n run", 32'(bn_run), 32'd640);
    chk("u1 hsync period", 32'(hs_period), 32'd800);
    chk("u1 hsync low", 32'(hs_low), 32'd96);
    chk("u1 hsync after blank", 32'(hs_after_bn), 32'd16);

    // Reduced geometry (24x12), latency 3: vertical timing over two frames
    rst_n[1] = 1'b1;
    #1;
    meas_reset();
    run_trace(1, 0, 709, "u3 frames trace");
    chk("u3 first frame_start", 32'(first_fs), 32'd4);
    chk("u3 frame_start spacing", 32'(fs_spacing), 32'd288);
    chk("u3 hsync period", 32'(hs_period), 32'd24);
    chk("u3 vsync low", 32'(vs_low), 32'd48);
    chk("u3 hsync per vsync", 32'(hs_per_vs), 32'd12);
    chk("u3 vsync after blank", 32'(vs_after_bn), 32'd32);
    chk("u3 blank_n run", 32'(bn_run), 32'd16);
    chk("u3 px2", 32'(po_hist[6]), 32'd1);
    chk("u3 px15", 32'(po_hist[19]), 32'd7);
    chk("u3 line2 px0", 32'(po_hist[52]), 32'd7);

    // Mid-frame reset: the current fetch cycle has display position h=10, v=5
    rst_n[1] = 1'b0;
    step();
    chk_reset(1, "u3 mid-frame reset");
    rst_n[1] = 1'b1;
    #1;
    meas_reset();
    run_trace(1, 0, 600, "u3 after mid-frame reset trace");
    chk("u3 restart frame_start", 32'(first_fs), 32'd4);
    chk("u3 restart spacing", 32'(fs_spacing), 32'd288);
    chk("u3 restart px2", 32'(po_hist[6]), 32'd1);

    // Latency 4: lookahead wraps across line and frame ends
    rst_n[2] = 1'b1;
    #1;
    meas_reset();
    run_trace(2, 0, 600, "u4 trace");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("u4 line7 tail read_enable %0d", k), 32'(re_hist[192+k]), 32'd0);
      chk($sformatf("u4 line11 tail read_enable %0d", k), 32'(re_hist[288+k]), 32'd1);
      chk($sformatf("u4 line11 tail y %0d", k), 32'(y_hist[288+k]), 32'd0);
    end
    chk("u4 line11 tail x0", 32'(x_hist[288]), 32'd0);
    chk("u4 line11 tail x1", 32'(x_hist[289]), 32'd0);
    chk("u4 line11 tail x2", 32'(x_hist[290]), 32'd1);
    chk("u4 line11 tail x3", 32'(x_hist[291]), 32'd1);
    chk("u4 first frame_start", 32'(first_fs), 32'd5);
    chk("u4 frame_start spacing", 32'(fs_spacing), 32'd288);
    chk("u4 first visible blank_n", 32'(bn_hist[293]), 32'd1);
    chk("u4 first visible pixel", 32'(po_hist[293]), 32'd0);
    chk("u4 pixel 2", 32'(po_hist[295]), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
